jtl_pulse_monitor: RTL

JTL_PULSE_MONITOR -- requirements
Module: jtl_pulse_monitor

---
 rtl/jtl_pulse_monitor.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/jtl_pulse_monitor.sv
// JTL pulse monitor: pairs every transition on the stimulus line with the next
// transition on the JTL output line and measures the delay between them.
// Pending stimulus timestamps wait in a small FIFO. Pulses that are matched
// too early, pending pulses that age out, unmatched output pulses and FIFO
// overflow each raise a sticky error flag.
module jtl_pulse_monitor #(
    parameter int DEPTH   = 4,
    parameter int TS_W    = 8,
    parameter int CNT_W   = 16,
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in,
    input  logic             out,
    output logic [CNT_W-1:0] pulse_cnt,
    output logic [TS_W-1:0]  last_dly,
    output logic             dly_valid,
    output logic             err_early,
    output logic             err_late,
    output logic             err_spurious,
    output logic             err_overflow,
    output logic             busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_FAULT} state_t;

    state_t            state_q, state_d;
    logic [TS_W-1:0]   fifo_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d, pop_cnt;
    logic [TS_W-1:0]   timer_q;
    logic              prev_in_q, prev_out_q;
    logic [CNT_W-1:0]  pulse_cnt_q, pulse_cnt_d, cnt_base;
    logic [TS_W-1:0]   last_dly_q;
    logic              dly_valid_q;
    logic              err_early_q, err_late_q, err_spurious_q, err_overflow_q;
    logic              err_early_d, err_late_d, err_spurious_d, err_overflow_d;
    logic              busy_q;

    logic              in_pulse, out_pulse, late_drop, match_avail, match;
    logic              spurious, early, full, push, overflow;
    logic [TS_W-1:0]   head_ts, next_ts, head_age, match_dly;

    // Pulse detection, late discard, matching and FIFO bookkeeping for this cycle.
    always_comb begin
        // NOTE: every signal gets a value before any condition, so no latch is inferred.
        in_pulse    = in ^ prev_in_q;
        out_pulse   = out ^ prev_out_q;
        head_ts     = fifo_q[rd_ptr_q];
        next_ts     = fifo_q[rd_ptr_q + PTR_W'(1)];
        head_age    = timer_q - head_ts;
        late_drop   = (occ_q != '0) && (head_age > TS_W'(MAX_DLY));
        // After a late discard the output pulse may still match the next entry.
        match_avail = late_drop ? (occ_q > OCC_W'(1)) : (occ_q != '0);
        match       = out_pulse && match_avail;
        spurious    = out_pulse && !match_avail;
        match_dly   = timer_q - (late_drop ? next_ts : head_ts);
        early       = match && (match_dly < TS_W'(MIN_DLY));
        full        = (occ_q == OCC_W'(DEPTH));
        // A pop in the same cycle frees the slot the push needs.
        push        = in_pulse && (!full || late_drop || match);
        overflow    = in_pulse && !push;
        pop_cnt     = OCC_W'(late_drop) + OCC_W'(match);
        occ_d       = occ_q - pop_cnt + OCC_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop_cnt);
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);

        // An error event in the same cycle as clr leaves the flag set.
        err_early_d    = (err_early_q    & ~clr) | early;
        err_late_d     = (err_late_q     & ~clr) | late_drop;
        err_spurious_d = (err_spurious_q & ~clr) | spurious;
        err_overflow_d = (err_overflow_q & ~clr) | overflow;

        cnt_base    = clr ? '0 : pulse_cnt_q;
        pulse_cnt_d = (match && (cnt_base != '1)) ? cnt_base + CNT_W'(1) : cnt_base;
    end

    // Controller next state: FAULT while any sticky flag is set, else by occupancy.
    always_comb begin
        state_d = state_q;
        if (err_early_d || err_late_d || err_spurious_d || err_overflow_d) begin
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_IDLE:  if (push)          state_d = S_TRACK;
                S_TRACK: if (occ_d == '0)   state_d = S_IDLE;
                default: state_d = (occ_d != '0) ? S_TRACK : S_IDLE;
            endcase
        end
    end

    // NOTE: the timestamp storage has no reset; occupancy and pointers decide validity.
    // Timestamp storage write port.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_q[wr_ptr_q] <= timer_q;
        end
    end

    // State registers; reset wins over clr and every pulse event.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q        <= S_IDLE;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            occ_q          <= '0;
            timer_q        <= '0;
            prev_in_q      <= in;
            prev_out_q     <= out;
            pulse_cnt_q    <= '0;
            last_dly_q     <= '0;
            dly_valid_q    <= 1'b0;
            err_early_q    <= 1'b0;
            err_late_q     <= 1'b0;
            err_spurious_q <= 1'b0;
            err_overflow_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            occ_q          <= occ_d;
            timer_q        <= timer_q + TS_W'(1);
            prev_in_q      <= in;
            prev_out_q     <= out;
            pulse_cnt_q    <= pulse_cnt_d;
            if (match) begin
                last_dly_q <= match_dly;
            end
            dly_valid_q    <= match;
            err_early_q    <= err_early_d;
            err_late_q     <= err_late_d;
            err_spurious_q <= err_spurious_d;
            err_overflow_q <= err_overflow_d;
            busy_q         <= (occ_d != '0);
        end
    end

    assign pulse_cnt    = pulse_cnt_q;
    assign last_dly     = last_dly_q;
    assign dly_valid    = dly_valid_q;
    assign err_early    = err_early_q;
    assign err_late     = err_late_q;
    assign err_spurious = err_spurious_q;
    assign err_overflow = err_overflow_q;
    assign busy         = busy_q;

endmodule
